// File: rtl/sram_port_if.sv
// Controller-to-RAM request channel: one request in, one done pulse plus read data back.
interface sram_req_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, done, rdata);
  modport slave  (input req, we, addr, wdata, output ready, done, rdata);
endinterface

// File: rtl/sram_port.sv
// Runs single timed read/write strobe sequences on the RAM1 SRAM pins.
// All pin controls and the data-bus drive enable come directly from flops.
module sram_port #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned WE_CYCLES = 2,
  parameter int unsigned RD_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  sram_req_if.slave         req_if,
  output logic [ADDR_W-1:0] Ram1Addr,
  inout  wire  [DATA_W-1:0] Ram1Data,
  output logic              Ram1OE,
  output logic              Ram1WE,
  output logic              Ram1EN,
  output logic              wrn,
  output logic              rdn
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_WAIT, DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_q;
  logic              oe_q;
  logic              we_q;
  logic              en_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      drive_q <= 1'b0;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      en_q    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_if.req) begin
            ready_q <= 1'b0;
            addr_q  <= req_if.addr;
            wdata_q <= req_if.wdata;
            en_q    <= 1'b0;
            if (req_if.we) begin
              state_q <= W_SETUP;
              drive_q <= 1'b1;
            end else begin
              state_q <= R_SETUP;
              oe_q    <= 1'b0;
            end
          end
        end
        W_SETUP: begin
          state_q <= W_PULSE;
          we_q    <= 1'b0;
          cnt_q   <= WE_LOAD;
        end
        W_PULSE: begin
          if (cnt_q == '0) begin
            state_q <= W_HOLD;
            we_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        // Address and data stay valid for one cycle after WE rises.
        W_HOLD: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          en_q    <= 1'b1;
          drive_q <= 1'b0;
        end
        R_SETUP: begin
          state_q <= R_WAIT;
          cnt_q   <= RD_LOAD;
        end
        R_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            rdata_q <= Ram1Data;
            done_q  <= 1'b1;
            oe_q    <= 1'b1;
            en_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          drive_q <= 1'b0;
          oe_q    <= 1'b1;
          we_q    <= 1'b1;
          en_q    <= 1'b1;
        end
      endcase
    end
  end

  assign req_if.ready = ready_q;
  assign req_if.done  = done_q;
  assign req_if.rdata = rdata_q;

  assign Ram1Addr = addr_q;
  assign Ram1OE   = oe_q;
  assign Ram1WE   = we_q;
  assign Ram1EN   = en_q;
  assign Ram1Data = drive_q ? wdata_q : {DATA_W{1'bz}};

  // UART shares Ram1Data; keep its strobes parked.
  assign wrn = 1'b1;
  assign rdn = 1'b1;

endmodule

// File: tb/tb_sram_port.sv
// Directed bench for sram_port with a small SRAM model on a pulled-up data bus.
module tb_sram_port;

  logic        CLK;
  logic        RST;
  logic [17:0] Ram1Addr;
  tri1  [15:0] Ram1Data;
  logic        Ram1OE, Ram1WE, Ram1EN, wrn, rdn;

  sram_req_if #(.ADDR_W(18), .DATA_W(16)) bus ();

  sram_port dut (
    .CLK(CLK), .RST(RST), .req_if(bus.slave),
    .Ram1Addr(Ram1Addr), .Ram1Data(Ram1Data),
    .Ram1OE(Ram1OE), .Ram1WE(Ram1WE), .Ram1EN(Ram1EN),
    .wrn(wrn), .rdn(rdn)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: writes on clock edges with WE and EN low, drives bus when OE and EN low.
  logic [15:0] mem [1024];
  logic        mem_clr;
  logic        sram_en;
  logic        wr_200;
  int          bus_bad;

  assign Ram1Data = (sram_en && !Ram1EN && !Ram1OE && Ram1WE) ? mem[Ram1Addr[9:0]] : 16'hzzzz;

  always @(posedge CLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'hA5A5;
      wr_200 <= 1'b0;
    end else if (!Ram1EN && !Ram1WE) begin
      mem[Ram1Addr[9:0]] <= Ram1Data;
      if (Ram1Addr == 18'h00200) wr_200 <= 1'b1;
    end
  end

  initial bus_bad = 0;
  always @(negedge CLK) begin
    if (!Ram1OE && !Ram1WE) bus_bad++;
    if (sram_en && !Ram1OE && !Ram1EN && Ram1Data !== mem[Ram1Addr[9:0]]) bus_bad++;
  end

  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] we_tr, oe_tr, en_tr, rdy_tr;
  logic [15:0] bus_tr [16];
  logic [17:0] addr_c2;
  int          done_cyc;
  int          ndone;

  // Issue one request from IDLE and trace cycles 1.. (cycle 1 follows the accepting edge).
  task automatic op(input logic w, input logic [17:0] a, input logic [15:0] d, input int inj);
    logic fin;
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge CLK);
    @(negedge CLK);
    bus.req = 1'b0;
    we_tr = '1; oe_tr = '1; en_tr = '1; rdy_tr = '0;
    done_cyc = 0; ndone = 0; fin = 1'b0; addr_c2 = '0;
    for (int k = 1; k <= 12; k++) begin
      if (!fin) begin
        if (k > 1) @(negedge CLK);
        if (k == inj + 1 && inj != 0) bus.req = 1'b0;
        we_tr[k]  = Ram1WE;
        oe_tr[k]  = Ram1OE;
        en_tr[k]  = Ram1EN;
        rdy_tr[k] = bus.ready;
        bus_tr[k] = Ram1Data;
        if (k == 2) addr_c2 = Ram1Addr;
        if (bus.done) begin
          ndone++;
          if (done_cyc == 0) done_cyc = k;
        end
        if (k == inj) begin
          bus.req = 1'b1; bus.we = 1'b1; bus.addr = 18'h00200; bus.wdata = 16'h5555;
        end
        if (done_cyc != 0 && k == done_cyc + 1) fin = 1'b1;
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    RST = 1'b0; mem_clr = 1'b1; sram_en = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      bus.req = 1'($urandom); bus.we = 1'($urandom);
      bus.addr = 18'($urandom); bus.wdata = 16'($urandom);
    end
    @(negedge CLK);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_strobes", 32'({Ram1OE, Ram1WE, Ram1EN}), 32'h7);
    check("rst_bus_z", 32'(Ram1Data), 32'hFFFF);
    check("rst_uart", 32'({wrn, rdn}), 32'h3);
    check("rst_rdata", 32'(bus.rdata), 32'h0);
    check("rst_addr", 32'(Ram1Addr), 32'h0);
    bus.req = 1'b0;
    mem_clr = 1'b0;
    RST = 1'b1;
    @(negedge CLK);

    // 2: write BEEF to 0x10
    op(1'b1, 18'h00010, 16'hBEEF, 0);
    check("wr_done_cyc", 32'(done_cyc), 32'd5);
    check("wr_ndone", 32'(ndone), 32'd1);
    check("wr_we_trace", 32'(we_tr[6:1]), 32'b111001);
    check("wr_en_trace", 32'(en_tr[6:1]), 32'b110000);
    check("wr_oe_trace", 32'(oe_tr[6:1]), 32'b111111);
    check("wr_ready_trace", 32'(rdy_tr[6:1]), 32'b100000);
    for (int k = 1; k <= 4; k++) check("wr_bus_data", 32'(bus_tr[k]), 32'hBEEF);
    check("wr_bus_released", 32'(bus_tr[5]), 32'hFFFF);
    check("wr_mem", 32'(mem[16]), 32'hBEEF);

    // 3: read with SRAM muted shows the DUT leaves the bus floating, then a real read
    sram_en = 1'b0;
    op(1'b0, 18'h00010, 16'h0000, 0);
    check("rdz_done_cyc", 32'(done_cyc), 32'd4);
    check("rdz_oe_trace", 32'(oe_tr[5:1]), 32'b11000);
    for (int k = 1; k <= 3; k++) check("rdz_bus_float", 32'(bus_tr[k]), 32'hFFFF);
    check("rdz_rdata", 32'(bus.rdata), 32'hFFFF);
    sram_en = 1'b1;
    op(1'b0, 18'h00010, 16'h0000, 0);
    check("rd_done_cyc", 32'(done_cyc), 32'd4);
    check("rd_ndone", 32'(ndone), 32'd1);
    check("rd_rdata", 32'(bus.rdata), 32'hBEEF);

    // 4: ten writes then ten reads; rdata must hold through the writes
    for (int i = 0; i < 10; i++) op(1'b1, 18'h00100 + 18'(i), 16'(i), 0);
    check("hold_rdata", 32'(bus.rdata), 32'hBEEF);
    for (int i = 0; i < 10; i++) begin
      op(1'b0, 18'h00100 + 18'(i), 16'h0000, 0);
      check("seq_rdata", 32'(bus.rdata), 32'(i));
    end
    check("bus_safety", 32'(bus_bad), 32'd0);

    // Top address passes through unmodified
    op(1'b1, 18'h3FFFF, 16'h1234, 0);
    check("top_addr", 32'(addr_c2), 32'h3FFFF);
    check("top_mem", 32'(mem[1023]), 32'h1234);

    // 5: request during W_PULSE is ignored
    op(1'b1, 18'h000F0, 16'h7777, 2);
    check("busy_ndone", 32'(ndone), 32'd1);
    check("busy_done_cyc", 32'(done_cyc), 32'd5);
    check("busy_mem", 32'(mem[240]), 32'h7777);
    check("busy_no_200", 32'(wr_200), 32'd0);
    check("busy_mem_200", 32'(mem[512]), 32'hA5A5);
    @(negedge CLK);
    check("busy_no_second", 32'(bus.ready), 32'd1);

    // 6: reset in the second W_PULSE cycle
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 18'h00300; bus.wdata = 16'h1111;
    @(posedge CLK);
    @(negedge CLK);
    bus.req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("mid_we_low", 32'(Ram1WE), 32'd0);
    RST = 1'b0;
    #1;
    check("mid_async_strobes", 32'({Ram1OE, Ram1WE, Ram1EN}), 32'h7);
    check("mid_async_bus", 32'(Ram1Data), 32'hFFFF);
    check("mid_async_ready", 32'(bus.ready), 32'd1);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (bus.done) ndone++;
    end
    check("mid_no_done", 32'(ndone), 32'd0);
    check("mid_rdata_clr", 32'(bus.rdata), 32'h0);
    RST = 1'b1;
    @(negedge CLK);
    check("post_ready", 32'(bus.ready), 32'd1);
    op(1'b0, 18'h00010, 16'h0000, 0);
    check("post_done_cyc", 32'(done_cyc), 32'd4);
    check("post_rdata", 32'(bus.rdata), 32'hBEEF);
    check("final_bus_safety", 32'(bus_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
